fir_ap_ctrl: RTL and testbench
==============================

// Module: fir_ap_ctrl
// PURPOSE
//   AXI-Lite control/config slave and sequencer for the FIR engine. Decodes the register
//   map (ap_ctrl, data_length, tap coefficients), owns the tap BRAM port and shares it
//   between AXI-Lite accesses and the engine, issues the engine start pulse, and tracks
//   ap_start/ap_done/ap_idle. Sits between the AXI-Lite bus and the FIR datapath.
// PARAMETERS
//   pADDR_WIDTH  12  AXI-Lite and BRAM address width
//   pDATA_WIDTH  32  data width
//   Tape_Num     11  number of taps; tap window 0x20 .. 0x20+4*(Tape_Num-1)
// PORTS
//   axis_clk    in  1   clock
//   axis_rst_n  in  1   asynchronous active-low reset
//   awvalid/awready in/out 1, awaddr in pADDR_WIDTH; wvalid/wready in/out 1, wdata in pDATA_WIDTH
//   arvalid/arready in/out 1, araddr in pADDR_WIDTH; rvalid out 1, rready in 1, rdata out pDATA_WIDTH
//   tap_WE out 4, tap_EN out 1, tap_Di out pDATA_WIDTH, tap_A out pADDR_WIDTH, tap_Do in pDATA_WIDTH
//   eng_tap_A   in  pADDR_WIDTH  engine tap read address (byte address, from 0)
//   eng_start   out 1   one-cycle start pulse to engine
//   eng_len     out 32  registered data_length presented to engine
//   eng_done    in  1   one-cycle pulse from engine: last output accepted
// BEHAVIOUR
//   Reset: all outputs 0 except ap_idle=1; data_length=0; ap_start=0, ap_done=0.
//   Register map: 0x00 ap_ctrl {bit2 ap_idle, bit1 ap_done, bit0 ap_start}; 0x10 data_length;
//     0x20+4k tap k -> tap BRAM addr 4k. Unmapped reads return 0; unmapped writes dropped.
//   Write channel: awready=wready=1 for exactly one cycle when awvalid&wvalid both high and
//     read FSM is idle; write takes effect on that edge. No partial aw/w acceptance.
//   Read FSM: R_IDLE -> (arvalid, no write this cycle) arready=1 -> R_WAIT (1 cycle, BRAM
//     latency) -> R_DATA rvalid=1, rdata held stable until rready -> R_IDLE.
//     Register reads also take R_WAIT (uniform 2-cycle ar->rvalid latency).
//   Simultaneous aw/w and ar valid in R_IDLE: write wins; read accepted next cycle.
//   Control FSM: IDLE (ap_idle=1) -> write 0x00 with bit0=1 -> ap_start=1, ap_idle=0 ->
//     next cycle eng_start=1 (1 cycle), ap_start=0 -> BUSY -> eng_done -> ap_done=1,
//     ap_idle=1 -> IDLE. ap_start write while BUSY ignored.
//   ap_done is clear-on-read: cleared on the cycle rvalid&rready completes a 0x00 read;
//     also cleared on new ap_start. eng_done in same cycle as clearing read: ap_done stays 1.
//   data_length and tap writes while BUSY are dropped; tap reads while BUSY return
//     0xFFFFFFFF and do not touch the BRAM; data_length reads always allowed.
//   Tap port mux: BUSY -> tap_EN=1, tap_WE=0, tap_A=eng_tap_A. IDLE -> AXI owns port;
//     tap write: tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x20, tap_Di=wdata for the accept cycle;
//     tap read: tap_EN=1, tap_WE=0, tap_A=araddr-0x20 in accept cycle, rdata<=tap_Do in R_WAIT.
//   eng_len updates only in IDLE (latched on data_length write).
//   Async reset mid-transaction: FSMs return to IDLE, pending rvalid dropped, taps in BRAM kept.
// TESTING
//   Reset -> read 0x00 returns 0x4; read 0x10 returns 0; rvalid 2 cycles after arready.
//   Write taps 0x20..0x48 = {0,-10,-9,23,56,63,56,23,-9,-10,0}, read back -> identical values.
//   Write 0x10=600, write 0x00=1 -> eng_start single pulse next cycle, 0x00 reads 0x0.
//   While BUSY: write 0x24=5 then read 0x24 -> 0xFFFFFFFF; after eng_done read 0x24 -> -10.
//   eng_done pulse -> read 0x00 = 0x6, second read = 0x4 (clear-on-read).
//   awvalid/wvalid and arvalid same cycle -> write accepted first, read returns written value.

Source files
------------

// File: rtl/fir_ap_ctrl.sv
// ----------------------------------------------------------------------------
// fir_ap_ctrl
//   AXI-Lite control/config slave and sequencer for the FIR engine.
//   - Decodes the register map: 0x00 ap_ctrl {ap_idle, ap_done, ap_start},
//     0x10 data_length, 0x20+4k tap coefficient k (tap BRAM byte address 4k).
//   - Owns the tap BRAM port and shares it between AXI-Lite and the engine.
//   - Issues a one-cycle start pulse to the engine and tracks ap_start,
//     ap_done (clear-on-read) and ap_idle.
//
// Ports
//   axis_clk, axis_rst_n          clock, asynchronous active-low reset
//   aw*/w*                        AXI-Lite write address/data (accepted together)
//   ar*/r*                        AXI-Lite read address/data
//   tap_WE/EN/Di/A, tap_Do        tap BRAM port (synchronous read, 1-cycle latency)
//   eng_tap_A                     engine tap read address (byte address from 0)
//   eng_start                     one-cycle start pulse to the engine
//   eng_len                       data_length as presented to the engine
//   eng_done                      one-cycle pulse: engine finished the run
// ----------------------------------------------------------------------------
module fir_ap_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    // AXI-Lite write
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    // AXI-Lite read
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    // Tap BRAM port
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    // Engine interface
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic                   eng_start,
    output logic [31:0]            eng_len,
    input  logic                   eng_done
);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32'h20);
    localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(32'h20 + 4 * (Tape_Num - 1));

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_START,
        C_BUSY
    } ctrl_state_t;

    rd_state_t               rd_state, rd_state_nxt;
    ctrl_state_t             ctrl_state, ctrl_state_nxt;

    logic                    ap_start;
    logic                    ap_done;
    logic                    ap_idle;
    logic                    busy;
    logic [31:0]             data_length;
    logic [pADDR_WIDTH-1:0]  rd_addr;
    logic                    rd_tap_blocked;
    logic [pDATA_WIDTH-1:0]  rdata_q;
    logic [pDATA_WIDTH-1:0]  rd_mux;
    logic                    eng_start_q;

    logic                    wr_accept;
    logic                    rd_accept;
    logic                    wr_start;
    logic                    wr_len;
    logic                    wr_tap;
    logic                    rd_tap;
    logic                    ctrl_read_done;

    // Word-aligned addresses inside the tap window; everything else is unmapped.
    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= TAP_BASE) && (a <= TAP_LAST) && (a[1:0] == 2'b00);
    endfunction

    // The BRAM port belongs to the engine from the start request until eng_done.
    assign busy    = (ctrl_state != C_IDLE);
    assign ap_idle = (ctrl_state == C_IDLE);
    assign ap_start = (ctrl_state == C_START);

    // A write needs both channels at once and an idle read FSM; it beats a
    // simultaneous read, which is then taken on the following cycle.
    assign wr_accept = awvalid && wvalid && (rd_state == R_IDLE);
    assign rd_accept = arvalid && (rd_state == R_IDLE) && !wr_accept;

    assign awready = wr_accept;
    assign wready  = wr_accept;
    assign arready = rd_accept;

    assign wr_start = wr_accept && (awaddr == ADDR_CTRL) && wdata[0] && !busy;
    assign wr_len   = wr_accept && (awaddr == ADDR_LEN) && !busy;
    assign wr_tap   = wr_accept && is_tap(awaddr) && !busy;
    assign rd_tap   = rd_accept && is_tap(araddr) && !busy;

    assign ctrl_read_done = (rd_state == R_DATA) && rready && (rd_addr == ADDR_CTRL);

    assign rvalid    = (rd_state == R_DATA);
    assign rdata     = rdata_q;
    assign eng_start = eng_start_q;
    assign eng_len   = data_length;

    // Read FSM next state: every read spends one cycle in R_WAIT so register
    // and BRAM reads share the same latency.
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (rd_accept) rd_state_nxt = R_WAIT;
            R_WAIT:  rd_state_nxt = R_DATA;
            R_DATA:  if (rready) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read data source, evaluated in R_WAIT when the BRAM output is valid.
    // A tap read that arrived while busy never touched the BRAM.
    always_comb begin
        rd_mux = '0;
        if (rd_addr == ADDR_CTRL) begin
            rd_mux = pDATA_WIDTH'({ap_idle, ap_done, ap_start});
        end else if (rd_addr == ADDR_LEN) begin
            rd_mux = pDATA_WIDTH'(data_length);
        end else if (is_tap(rd_addr)) begin
            rd_mux = rd_tap_blocked ? '1 : tap_Do;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rd_state       <= R_IDLE;
            rd_addr        <= '0;
            rd_tap_blocked <= 1'b0;
            rdata_q        <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            if (rd_accept) begin
                rd_addr        <= araddr;
                rd_tap_blocked <= busy;
            end
            if (rd_state == R_WAIT) begin
                rdata_q <= rd_mux;
            end
        end
    end

    // Control FSM next state: C_START lasts one cycle (ap_start visible),
    // then C_BUSY until the engine reports completion.
    always_comb begin
        ctrl_state_nxt = ctrl_state;
        case (ctrl_state)
            C_IDLE:  if (wr_start) ctrl_state_nxt = C_START;
            C_START: ctrl_state_nxt = C_BUSY;
            C_BUSY:  if (eng_done) ctrl_state_nxt = C_IDLE;
            default: ctrl_state_nxt = C_IDLE;
        endcase
    end

    // ap_done set by eng_done has priority over the clear-on-read so a
    // completion coinciding with the read handshake is not lost.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ctrl_state  <= C_IDLE;
            ap_done     <= 1'b0;
            eng_start_q <= 1'b0;
            data_length <= '0;
        end else begin
            ctrl_state  <= ctrl_state_nxt;
            eng_start_q <= (ctrl_state == C_START);
            if ((ctrl_state == C_BUSY) && eng_done) begin
                ap_done <= 1'b1;
            end else if (wr_start || ctrl_read_done) begin
                ap_done <= 1'b0;
            end
            if (wr_len) begin
                data_length <= 32'(wdata);
            end
        end
    end

    // Tap BRAM port ownership.
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (busy) begin
            tap_EN = 1'b1;
            tap_A  = eng_tap_A;
        end else if (wr_tap) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = awaddr - TAP_BASE;
            tap_Di = wdata;
        end else if (rd_tap) begin
            tap_EN = 1'b1;
            tap_A  = araddr - TAP_BASE;
        end
    end

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fir_ap_ctrl
//   Self-checking bench for fir_ap_ctrl: register map vectors, start/done
//   sequencing, busy-time access rules, write/read collision, async reset
//   during a read, and randomized register traffic against a reference model.
// ----------------------------------------------------------------------------
module tb_fir_ap_ctrl;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [11:0] awaddr = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic        arvalid = 1'b0, arready;
    logic [11:0] araddr = '0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [31:0] tap_Di;
    logic [11:0] tap_A;
    logic [31:0] tap_Do = '0;
    logic [11:0] eng_tap_A = '0;
    logic        eng_start;
    logic [31:0] eng_len;
    logic        eng_done = 1'b0;

    int total = 0;
    int bad = 0;
    int startPulses = 0;

    typedef struct packed {
        logic        isWrite;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    // Reference register map kept by the bench (idle-time view).
    logic [31:0] refTap [11];
    logic [31:0] refLen = '0;
    logic        refDone = 1'b0;

    logic [31:0] bram [0:1023];

    fir_ap_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .tap_WE     (tap_WE),
        .tap_EN     (tap_EN),
        .tap_Di     (tap_Di),
        .tap_A      (tap_A),
        .tap_Do     (tap_Do),
        .eng_tap_A  (eng_tap_A),
        .eng_start  (eng_start),
        .eng_len    (eng_len),
        .eng_done   (eng_done)
    );

    always #5 axis_clk = ~axis_clk;

    // Byte-enabled synchronous BRAM, read-first, word index = byte address / 4.
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            for (int b = 0; b < 4; b++) begin
                if (tap_WE[b]) bram[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
            end
            tap_Do <= bram[tap_A[11:2]];
        end
    end

    always @(negedge axis_clk) begin
        if (axis_rst_n && eng_start) startPulses++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, required);
        end
    endtask

    // All bus tasks start and end at 1 time unit after a rising edge.
    task automatic axiWrite(input logic [11:0] a, input logic [31:0] d);
        bit got = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            #2;
            if (awready === 1'b1 && wready === 1'b1) got = 1;
            @(posedge axis_clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("[TB] FAIL write 0x%03h: no awready/wready within 20 cycles", a);
        end
    endtask

    task automatic arPhase(input logic [11:0] a, output bit ok);
        ok = 0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #2;
            if (arready === 1'b1) ok = 1;
            @(posedge axis_clk); #1;
        end
        arvalid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("[TB] FAIL read 0x%03h: no arready within 20 cycles", a);
        end
    endtask

    // Waits for rvalid; lat=1 means the cycle right after the arready cycle.
    // With doReady=0 it returns mid-cycle (edge+3) while rvalid is high.
    task automatic waitR(input bit doReady, output logic [31:0] d, output int lat);
        bit got = 0;
        int i = 1;
        d = 'x; lat = 0;
        rready = doReady;
        while (!got && i <= 20) begin
            #2;
            if (rvalid === 1'b1) begin
                got = 1; lat = i; d = rdata;
            end else begin
                @(posedge axis_clk); #1; i++;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("[TB] FAIL rvalid: not seen within 20 cycles");
        end else if (doReady) begin
            @(posedge axis_clk); #1;
        end
        rready = 1'b0;
    endtask

    task automatic axiRead(input logic [11:0] a, output logic [31:0] d, output int lat);
        bit ok;
        arPhase(a, ok);
        d = 'x; lat = 0;
        if (ok) waitR(1'b1, d, lat);
    endtask

    task automatic readCheck(input string name, input logic [11:0] a, input logic [31:0] required);
        logic [31:0] d;
        int lat;
        axiRead(a, d, lat);
        checkOutput(name, d, required);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.isWrite) axiWrite(v.addr, v.data);
        else readCheck($sformatf("vec read 0x%03h", v.addr), v.addr, v.expData);
    endtask

    task automatic pulseDone();
        eng_done = 1'b1;
        @(posedge axis_clk); #1;
        eng_done = 1'b0;
    endtask

    function automatic logic [31:0] refRead(input logic [11:0] a);
        if (a == 12'h000) return {29'd0, 1'b1, refDone, 1'b0};
        if (a == 12'h010) return refLen;
        if (a >= 12'h020 && a <= 12'h048 && a[1:0] == 2'b00) return refTap[(a - 12'h020) / 4];
        return 32'd0;
    endfunction

    function automatic logic [11:0] pickAddr();
        logic [11:0] unmapped [10];
        unmapped = '{12'h004, 12'h008, 12'h00C, 12'h014, 12'h018, 12'h01C,
                     12'h04C, 12'h050, 12'h100, 12'hFFC};
        case ($urandom_range(0, 3))
            0, 1:    return 12'h020 + 12'(4 * $urandom_range(0, 10));
            2:       return unmapped[$urandom_range(0, 9)];
            default: return ($urandom_range(0, 1) == 0) ? 12'h010 : 12'h000;
        endcase
    endfunction

    initial begin
        int tapVals [11];
        logic [31:0] d;
        logic [31:0] first;
        int lat;
        int p0;
        bit ok;
        tapVals = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        for (int i = 0; i < 1024; i++) bram[i] = 32'd0;

        // ---------------- reset ----------------
        repeat (3) @(posedge axis_clk);
        #1;
        checkOutput("reset awready", {31'd0, awready}, 32'd0);
        checkOutput("reset rvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("reset tap_EN", {31'd0, tap_EN}, 32'd0);
        checkOutput("reset eng_start", {31'd0, eng_start}, 32'd0);
        checkOutput("reset eng_len", eng_len, 32'd0);
        checkOutput("reset rdata", rdata, 32'd0);
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;

        axiRead(12'h000, d, lat);
        checkOutput("ap_ctrl after reset", d, 32'h4);
        checkOutput("read latency", 32'(lat), 32'd2);
        readCheck("data_length after reset", 12'h010, 32'd0);

        // ---------------- table vectors ----------------
        for (int k = 0; k < 11; k++)
            vecs.push_back('{1'b1, 12'(12'h020 + 4 * k), 32'(tapVals[k]), 32'd0});
        for (int k = 0; k < 11; k++)
            vecs.push_back('{1'b0, 12'(12'h020 + 4 * k), 32'd0, 32'(tapVals[k])});
        vecs.push_back('{1'b1, 12'h010, 32'd600, 32'd0});
        vecs.push_back('{1'b0, 12'h010, 32'd0, 32'd600});
        vecs.push_back('{1'b1, 12'h04C, 32'h5555_AAAA, 32'd0});
        vecs.push_back('{1'b0, 12'h04C, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 12'h004, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 12'h048, 32'd0, 32'd0});
        foreach (vecs[i]) applyStimulus(vecs[i]);
        for (int k = 0; k < 11; k++) refTap[k] = 32'(tapVals[k]);
        refLen = 32'd600;
        checkOutput("eng_len latched", eng_len, 32'd600);

        // ---------------- start / busy ----------------
        p0 = startPulses;
        axiWrite(12'h000, 32'h1);
        #2; checkOutput("eng_start not yet", {31'd0, eng_start}, 32'd0);
        @(posedge axis_clk); #1;
        #2; checkOutput("eng_start pulse", {31'd0, eng_start}, 32'd1);
        @(posedge axis_clk); #1;
        #2; checkOutput("eng_start drop", {31'd0, eng_start}, 32'd0);
        eng_tap_A = 12'h014;
        #1;
        checkOutput("busy tap_A", {20'd0, tap_A}, 32'h014);
        checkOutput("busy tap_EN", {31'd0, tap_EN}, 32'd1);
        checkOutput("busy tap_WE", {28'd0, tap_WE}, 32'd0);
        @(posedge axis_clk); #1;
        readCheck("ap_ctrl busy", 12'h000, 32'h0);
        axiWrite(12'h024, 32'd5);
        readCheck("tap read busy", 12'h024, 32'hFFFF_FFFF);
        axiWrite(12'h010, 32'd7);
        readCheck("len write busy dropped", 12'h010, 32'd600);
        checkOutput("eng_len busy", eng_len, 32'd600);
        axiWrite(12'h000, 32'h1);
        repeat (3) @(posedge axis_clk);
        #1;
        checkOutput("single start pulse", 32'(startPulses - p0), 32'd1);
        pulseDone();
        readCheck("ap_ctrl done", 12'h000, 32'h6);
        readCheck("ap_ctrl cleared", 12'h000, 32'h4);
        readCheck("tap kept after busy", 12'h024, 32'hFFFF_FFF6);
        #2; checkOutput("idle tap_EN", {31'd0, tap_EN}, 32'd0);
        @(posedge axis_clk); #1;

        // eng_done while idle has no effect
        pulseDone();
        readCheck("done ignored idle", 12'h000, 32'h4);

        // ---------------- write/read collision ----------------
        awaddr = 12'h028; wdata = 32'h0000_1234; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 12'h028; arvalid = 1'b1;
        #2;
        checkOutput("collide awready", {31'd0, awready}, 32'd1);
        checkOutput("collide arready", {31'd0, arready}, 32'd0);
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        #2;
        checkOutput("collide arready next", {31'd0, arready}, 32'd1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        waitR(1'b1, d, lat);
        checkOutput("collide read data", d, 32'h0000_1234);
        refTap[2] = 32'h0000_1234;

        // ---------------- eng_done on the clearing handshake ----------------
        axiWrite(12'h000, 32'h1);
        repeat (2) @(posedge axis_clk);
        #1;
        arPhase(12'h000, ok);
        waitR(1'b0, first, lat);
        @(posedge axis_clk); #1;
        #2;
        checkOutput("rdata hold", rdata, first);
        checkOutput("rvalid hold", {31'd0, rvalid}, 32'd1);
        @(posedge axis_clk); #1;
        rready = 1'b1; eng_done = 1'b1;
        @(posedge axis_clk); #1;
        rready = 1'b0; eng_done = 1'b0;
        checkOutput("held read value", first, 32'h0);
        readCheck("done kept on collide", 12'h000, 32'h6);
        readCheck("done cleared later", 12'h000, 32'h4);

        // new ap_start clears a pending ap_done
        axiWrite(12'h000, 32'h1);
        repeat (2) @(posedge axis_clk);
        #1;
        pulseDone();
        axiWrite(12'h000, 32'h1);
        readCheck("start clears done", 12'h000, 32'h0);
        pulseDone();
        readCheck("second run done", 12'h000, 32'h6);
        readCheck("second run cleared", 12'h000, 32'h4);

        // ---------------- randomized idle traffic ----------------
        for (int n = 0; n < 60; n++) begin
            logic [11:0] a;
            a = pickAddr();
            if ($urandom_range(0, 1) == 0 && a != 12'h000) begin
                logic [31:0] v;
                v = $urandom;
                axiWrite(a, v);
                if (a == 12'h010) refLen = v;
                else if (a >= 12'h020 && a <= 12'h048) refTap[(a - 12'h020) / 4] = v;
            end else begin
                readCheck($sformatf("rand read 0x%03h", a), a, refRead(a));
                if (a == 12'h000) refDone = 1'b0;
            end
        end
        checkOutput("rand eng_len", eng_len, refLen);

        // ---------------- async reset during a pending read ----------------
        arPhase(12'h02C, ok);
        waitR(1'b0, d, lat);
        axis_rst_n = 1'b0;
        #1;
        checkOutput("reset drops rvalid", {31'd0, rvalid}, 32'd0);
        repeat (2) @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        refLen = 32'd0;
        @(posedge axis_clk); #1;
        readCheck("tap kept over reset", 12'h02C, refTap[3]);
        readCheck("len reset", 12'h010, 32'd0);
        readCheck("ap_ctrl after reset2", 12'h000, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
